one_unit_acc: RTL and testbench
===============================

Name: one_unit_acc

Overview:
- Consumer end of the one-unit product stream.
- Receives per-sample 4x4 product beats, z multiplied by (z^T w)^3, in Q13 26-bit fixed point.
- Accumulates N beats, divides by N (arithmetic shift) and subtracts 3*w per element, yielding the FastICA fixed-point update w+ = E{z g(w^T z)} - 3w for 4 units x 4 elements.
- Sits between the product multiplier and the orthogonalisation/normalisation stage.

Parameters:
- DATA_W, 26, element width (signed, Q13)
- LOG2_N, 10, log2 of samples per iteration; N = 2^LOG2_N
- GUARD, 2, extra accumulator headroom bits

Ports:
- clk_acc  in  1  clock
- rst_acc  in  1  synchronous active-high reset
- start  in  1  begin an iteration; sampled only in IDLE
- w_in  in  16*DATA_W  current weights, element (u,k) at bits [(4*(u-1)+(k-1))*DATA_W +: DATA_W]; captured on start
- prod_valid  in  1  prod_in beat valid
- prod_ready  out  1  block accepts a beat
- prod_in  in  16*DATA_W  product beat, same (u,k) packing as w_in
- w_out  out  16*DATA_W  updated weights, same packing; held until next FINAL
- done  out  1  one-cycle pulse, w_out valid
- busy  out  1  high in ACCUM, FINAL, DONE

Behaviour:
- Reset (rst_acc=1 at a clock edge, any state):
  - state=IDLE; all accumulators, beat counter and w_out cleared to 0.
  - prod_ready=0, done=0, busy=0.
  - Reset mid-iteration discards partial sums; no done pulse.
- IDLE:
  - prod_ready=0.
  - On start=1: capture w_in into w_reg, clear accumulators and counter, go to ACCUM.
- ACCUM:
  - prod_ready=1.
  - A beat transfers when prod_valid & prod_ready: acc[i] += sign-extended prod_in[i] for all 16 lanes, counter += 1.
  - When the transferring beat has counter == N-1: go to FINAL; prod_ready drops the next cycle.
  - Gaps in prod_valid stall the block without penalty.
  - start is ignored in every state except IDLE.
- FINAL (one cycle), per lane:
  - mean = acc >>> LOG2_N, arithmetic, truncating toward -inf.
  - three_w = (w_reg <<< 1) + w_reg, computed at DATA_W+2 bits.
  - diff = mean - three_w, at DATA_W+LOG2_N+GUARD bits.
  - Saturate diff to the DATA_W signed range: max 2^(DATA_W-1)-1 = 33554431, min -2^(DATA_W-1) = -33554432.
  - Register the result into w_out; go to DONE.
- DONE (one cycle): done=1; go to IDLE.
- Latency: done asserts 2 cycles after the clock edge that accepted the last beat. w_out updates on the same edge that raises done.
- Width rule: accumulator width is DATA_W+LOG2_N+GUARD = 38 bits by default. No wrap is possible for in-range inputs.
- Q13 is preserved throughout: the division is a pure shift and 3w needs no rescale.

Decomposition:
- Shared package one_unit_pkg:
  - constants DATA_W=26, Q_FRAC=13
  - state enum {IDLE, ACCUM, FINAL, DONE}
  - function sat_dataw(wide) -> DATA_W
- Sub-module acc_lane: one lane, instantiated 16 times.
  - Inputs: clear, add_en, prod, w, fin_en.
  - Holds the accumulator and the w_reg slice.
  - Produces the saturated result.
- The top level holds the FSM, beat counter and packing.

Test Plan (LOG2_N=2, N=4):
- Basic: all 16 prod lanes = 8192 (1.0) for 4 beats, w_in all 0 -> done pulse 2 cycles after the 4th accept; every w_out lane = 8192.
- Sign/3w: prod lanes = -8192 x4, w_in lanes = 8192 -> every w_out lane = -8192 - 24576 = -32768.
- Saturation: prod lanes = 33554431 x4, w_in lanes = -16777216 -> diff exceeds max; every w_out lane = 33554431. A mirror case with negatives gives -33554432.
- Backpressure/gaps: prod_valid pattern 1,0,0,1,1,0,1 with distinct lane values 100,200,300,400 -> only 4 beats counted; w_out = floor(1000/4) = 250 with w=0; prod_ready low in IDLE and FINAL.
- Control: start pulsed during ACCUM -> no restart, counter continues. rst_acc asserted after 2 beats -> next cycle prod_ready=0, busy=0, w_out=0, no done. A fresh start then completes normally.

Source files
------------

// File: rtl/one_unit_pkg.sv
// rtl/one_unit_pkg.sv - shared constants, state type and saturation helper for the one-unit accumulator
package one_unit_pkg;

    localparam int DATA_W = 26;
    localparam int Q_FRAC = 13;
    localparam int WIDE_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        DONE
    } state_t;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [WIDE_W-1:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

    // Clamp a sign-extended wide value into the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat_dataw(input logic signed [WIDE_W-1:0] wide);
        logic signed [WIDE_W-1:0] clamped;
        clamped = wide;
        if (wide > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (wide < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        return clamped[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/one_unit_acc_lane.sv
// rtl/one_unit_acc_lane.sv - one accumulator lane: sums product beats, then mean - 3w with saturation
module acc_lane
    import one_unit_pkg::*;
#(
    parameter int DATA_W = one_unit_pkg::DATA_W,
    parameter int LOG2_N = 10,
    parameter int GUARD  = 2
) (
    input  logic                     clk_acc,
    input  logic                     rst_acc,
    input  logic                     clear,
    input  logic                     add_en,
    input  logic signed [DATA_W-1:0] prod,
    input  logic signed [DATA_W-1:0] w,
    input  logic                     fin_en,
    output logic signed [DATA_W-1:0] result
);

    localparam int ACC_W = DATA_W + LOG2_N + GUARD;

    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] w_reg;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  mean;
    logic signed [DATA_W+1:0] w_x;
    logic signed [DATA_W+1:0] three_w;
    logic signed [ACC_W-1:0]  three_w_x;
    logic signed [ACC_W-1:0]  diff;
    logic signed [WIDE_W-1:0] diff_x;

    // Dividing by N is a pure arithmetic shift, so the Q13 scaling carries straight through.
    always_comb begin
        prod_x    = {{(ACC_W - DATA_W){prod[DATA_W-1]}}, prod};
        mean      = acc >>> LOG2_N;
        w_x       = {{2{w_reg[DATA_W-1]}}, w_reg};
        three_w   = (w_x <<< 1) + w_x;
        three_w_x = {{(ACC_W - DATA_W - 2){three_w[DATA_W+1]}}, three_w};
        diff      = mean - three_w_x;
        diff_x    = {{(WIDE_W - ACC_W){diff[ACC_W-1]}}, diff};
    end

    always_ff @(posedge clk_acc) begin
        if (rst_acc) begin
            acc    <= '0;
            w_reg  <= '0;
            result <= '0;
        end else begin
            if (clear) begin
                acc   <= '0;
                w_reg <= w;
            end else if (add_en) begin
                acc <= acc + prod_x;
            end
            if (fin_en) begin
                result <= sat_dataw(diff_x);
            end
        end
    end

endmodule

// File: rtl/one_unit_acc.sv
// rtl/one_unit_acc.sv - FastICA one-unit update: accumulate N product beats, w+ = mean - 3w for 16 lanes
module one_unit_acc
    import one_unit_pkg::*;
#(
    parameter int DATA_W = one_unit_pkg::DATA_W,
    parameter int LOG2_N = 10,
    parameter int GUARD  = 2
) (
    input  logic                   clk_acc,
    input  logic                   rst_acc,
    input  logic                   start,
    input  logic [16*DATA_W-1:0]   w_in,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    input  logic [16*DATA_W-1:0]   prod_in,
    output logic [16*DATA_W-1:0]   w_out,
    output logic                   done,
    output logic                   busy
);

    state_t            state;
    logic [LOG2_N-1:0] beat_cnt;
    logic              accept;
    logic              clear;
    logic              fin_en;

    assign accept = prod_valid & prod_ready;
    assign clear  = (state == IDLE) & start;
    assign fin_en = (state == FINAL);

    // Outputs are registered alongside the state so they never glitch with the inputs.
    always_ff @(posedge clk_acc) begin
        if (rst_acc) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            prod_ready <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        beat_cnt   <= '0;
                        prod_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == {LOG2_N{1'b1}}) begin
                            state      <= FINAL;
                            prod_ready <= 1'b0;
                        end
                    end
                end
                FINAL: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    prod_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_lane
        acc_lane #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N),
            .GUARD  (GUARD)
        ) u_lane (
            .clk_acc (clk_acc),
            .rst_acc (rst_acc),
            .clear   (clear),
            .add_en  (accept),
            .prod    (prod_in[i*DATA_W +: DATA_W]),
            .w       (w_in[i*DATA_W +: DATA_W]),
            .fin_en  (fin_en),
            .result  (w_out[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_one_unit_acc.sv
// tb/tb_one_unit_acc.sv - self-checking bench for one_unit_acc with N=4
module tb_one_unit_acc;

    localparam int DW  = 26;
    localparam int L2N = 2;
    localparam int N   = 4;
    localparam int LW  = 16 * DW;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic          clk_acc = 1'b0;
    logic          rst_acc;
    logic          start;
    logic [LW-1:0] w_in;
    logic          prod_valid;
    logic          prod_ready;
    logic [LW-1:0] prod_in;
    logic [LW-1:0] w_out;
    logic          done;
    logic          busy;

    int     n_vec = 0;
    int     n_err = 0;
    longint sum [16];
    longint wv  [16];
    int     nb;

    always #5 clk_acc = ~clk_acc;

    one_unit_acc #(.DATA_W(DW), .LOG2_N(L2N), .GUARD(2)) dut (
        .clk_acc    (clk_acc),
        .rst_acc    (rst_acc),
        .start      (start),
        .w_in       (w_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_in    (prod_in),
        .w_out      (w_out),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_acc);
        #1;
    endtask

    function automatic logic [LW-1:0] pack(input longint v [16]);
        logic [LW-1:0] p;
        longint        t;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            t = v[i];
            p[i*DW +: DW] = t[DW-1:0];
        end
        return p;
    endfunction

    function automatic longint rnd(input int bits);
        return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) <<< (bits - 1));
    endfunction

    // Reference: w+ = floor(sum / N) - 3w, clamped to the signed DW range.
    function automatic logic [LW-1:0] model_wout();
        longint q, d;
        longint r [16];
        for (int i = 0; i < 16; i++) begin
            q = sum[i] / N;
            if ((sum[i] % N) != 0 && sum[i] < 0) q = q - 1;
            d = q - 3 * wv[i];
            if (d > MAXV) d = MAXV;
            if (d < MINV) d = MINV;
            r[i] = d;
        end
        return pack(r);
    endfunction

    task automatic begin_iter(input longint w [16]);
        for (int i = 0; i < 16; i++) begin
            wv[i]  = w[i];
            sum[i] = 0;
        end
        nb    = 0;
        w_in  = pack(w);
        start = 1'b1;
        tick();
        start = 1'b0;
        w_in  = '0;
        chk("ready_after_start", LW'(prod_ready), LW'(1'b1));
        chk("busy_after_start", LW'(busy), LW'(1'b1));
    endtask

    task automatic beat(input logic valid, input longint v [16]);
        logic exp_rdy;
        exp_rdy    = (nb < N);
        prod_valid = valid;
        prod_in    = pack(v);
        chk("ready_accum", LW'(prod_ready), LW'(exp_rdy));
        tick();
        if (valid && exp_rdy) begin
            for (int i = 0; i < 16; i++) sum[i] += v[i];
            nb++;
        end
        prod_valid = 1'b0;
        prod_in    = '0;
    endtask

    task automatic finish_iter(input string tag);
        logic [LW-1:0] e;
        e = model_wout();
        chk({tag, "_ready_final"}, LW'(prod_ready), LW'(1'b0));
        chk({tag, "_done_early"}, LW'(done), LW'(1'b0));
        tick();
        chk({tag, "_done"}, LW'(done), LW'(1'b1));
        chk({tag, "_wout"}, w_out, e);
        tick();
        chk({tag, "_done_pulse"}, LW'(done), LW'(1'b0));
        chk({tag, "_busy_idle"}, LW'(busy), LW'(1'b0));
        chk({tag, "_ready_idle"}, LW'(prod_ready), LW'(1'b0));
        chk({tag, "_wout_hold"}, w_out, e);
    endtask

    task automatic fill(output longint a [16], input longint val);
        for (int i = 0; i < 16; i++) a[i] = val;
    endtask

    initial begin
        longint w [16];
        longint v [16];
        longint junk [16];
        int     guard_cnt;

        rst_acc    = 1'b1;
        start      = 1'b0;
        prod_valid = 1'b0;
        w_in       = '0;
        prod_in    = '0;
        tick();
        tick();
        rst_acc = 1'b0;
        chk("rst_ready", LW'(prod_ready), LW'(1'b0));
        chk("rst_done", LW'(done), LW'(1'b0));
        chk("rst_busy", LW'(busy), LW'(1'b0));
        chk("rst_wout", w_out, '0);

        // Basic: 1.0 everywhere, w = 0.
        fill(w, 0);
        fill(v, 8192);
        begin_iter(w);
        for (int k = 0; k < N; k++) beat(1'b1, v);
        finish_iter("basic");

        // Sign and 3w.
        fill(w, 8192);
        fill(v, -8192);
        begin_iter(w);
        for (int k = 0; k < N; k++) beat(1'b1, v);
        finish_iter("sign3w");

        // Positive and negative saturation.
        fill(w, -16777216);
        fill(v, MAXV);
        begin_iter(w);
        for (int k = 0; k < N; k++) beat(1'b1, v);
        finish_iter("sat_pos");
        fill(w, 16777216);
        fill(v, MINV);
        begin_iter(w);
        for (int k = 0; k < N; k++) beat(1'b1, v);
        finish_iter("sat_neg");

        // Gaps in prod_valid: pattern 1,0,0,1,1,0,1.
        fill(w, 0);
        fill(junk, 9999);
        begin_iter(w);
        fill(v, 100); beat(1'b1, v);
        beat(1'b0, junk);
        beat(1'b0, junk);
        fill(v, 200); beat(1'b1, v);
        fill(v, 300); beat(1'b1, v);
        beat(1'b0, junk);
        fill(v, 400); beat(1'b1, v);
        finish_iter("gaps");

        // start during ACCUM must not restart the iteration.
        for (int i = 0; i < 16; i++) w[i] = 1000 * i - 7000;
        begin_iter(w);
        for (int i = 0; i < 16; i++) v[i] = 5000 + 37 * i;
        beat(1'b1, v);
        start = 1'b1;
        beat(1'b1, v);
        start = 1'b0;
        beat(1'b1, v);
        beat(1'b1, v);
        finish_iter("start_ignored");

        // Reset mid-iteration discards everything.
        fill(w, 12345);
        fill(v, 40000);
        begin_iter(w);
        beat(1'b1, v);
        beat(1'b1, v);
        rst_acc = 1'b1;
        tick();
        rst_acc = 1'b0;
        chk("midrst_ready", LW'(prod_ready), LW'(1'b0));
        chk("midrst_busy", LW'(busy), LW'(1'b0));
        chk("midrst_wout", w_out, '0);
        chk("midrst_done", LW'(done), LW'(1'b0));
        prod_valid = 1'b1;
        prod_in    = pack(v);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_no_done", LW'(done), LW'(1'b0));
            chk("midrst_idle_ready", LW'(prod_ready), LW'(1'b0));
        end
        prod_valid = 1'b0;
        prod_in    = '0;
        fill(w, -3000);
        fill(v, -77777);
        begin_iter(w);
        for (int k = 0; k < N; k++) beat(1'b1, v);
        finish_iter("after_rst");

        // Randomized iterations with random valid gaps.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) w[i] = rnd(25);
            begin_iter(w);
            guard_cnt = 0;
            while (nb < N && guard_cnt < 200) begin
                for (int i = 0; i < 16; i++) v[i] = rnd(26);
                beat(1'($urandom_range(0, 1)), v);
                guard_cnt++;
            end
            chk("rand_beat_budget", LW'(nb), LW'(N));
            finish_iter("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
